shlr_seq_ctrl: RTL and testbench

//  Sequencer for the n-bit logical-right-shift datapath. Takes a load value
//  and a shift amount, then applies one 1-bit shlr step per clock until the

---
 rtl/shlr_seq_ctrl.sv | 111 +++++++++++
 tb/tb_shlr_seq_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/shlr_seq_ctrl.sv
// Sequencer for an n-bit logical right shift: loads a word and a shift count,
// steps one zero-fill shift per clock, streams shifted-out bits, then pulses done.
module shlr_seq_ctrl #(
    parameter int SIZE  = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIZE-1:0]  din,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [SIZE-1:0]  result,
    output logic             carry,
    output logic             sout,
    output logic             sout_vld
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SIZE-1:0]  data_q, data_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sout_vld_q, sout_vld_d;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sout_vld_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    data_d  = din;
                    cnt_d   = amt;
                    carry_d = 1'b0;
                    busy_d  = 1'b1;
                    if (amt == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = SHIFT;
                        sout_vld_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                data_d  = {1'b0, data_q[SIZE-1:1]};
                carry_d = data_q[0];
                cnt_d   = cnt_q - AMT_W'(1);
                busy_d  = 1'b1;
                // Last step: the count reaches zero here and is never wrapped.
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    sout_vld_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sout_vld_q <= sout_vld_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = data_q;
    assign carry    = carry_q;
    assign sout     = data_q[0];
    assign sout_vld = sout_vld_q;

endmodule

// File: tb/tb_shlr_seq_ctrl.sv
// Bench for shlr_seq_ctrl: table-driven requests with a result/sout scoreboard,
// plus hand-written reset, ignored-start and held-start sequences.
module tb_shlr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] din;
    logic [2:0] amt;
    logic       busy, done, carry, sout, sout_vld;
    logic [3:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] din;
        logic [2:0] amt;
        logic [3:0] res;
        logic       c;
    } vec_t;

    typedef struct {
        logic [3:0] res;
        logic       c;
        int         nshift;
    } exp_t;

    exp_t sb[$];
    logic sq[$];
    vec_t vecs[9];

    shlr_seq_ctrl #(.SIZE(4), .AMT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .amt(amt),
        .busy(busy), .done(done), .result(result), .carry(carry),
        .sout(sout), .sout_vld(sout_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Record the expected outcome and sout stream for a request about to be accepted.
    task automatic push_exp(input logic [3:0] d, input logic [2:0] a,
                            input logic [3:0] r, input logic c);
        exp_t e;
        e.res = r; e.c = c; e.nshift = int'(a);
        sb.push_back(e);
        for (int k = 0; k < int'(a); k++)
            sq.push_back(k < 4 ? d[k] : 1'b0);
    endtask

    // Called just after the accept edge; follows the request to its done pulse.
    task automatic wait_done(input int lat_exp);
        int   cyc = 0, nvld = 0, nbusy = 0;
        bit   got = 0;
        exp_t e;
        logic b;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) nbusy++;
            if (sout_vld) begin
                nvld++;
                if (sq.size() > 0) begin
                    b = sq.pop_front();
                    chk("sout", 32'(sout), 32'(b));
                end else chk("sout_extra", 1, 0);
            end
            if (done) got = 1;
        end
        if (!got || sb.size() == 0) begin
            chk("done_timeout", 0, 1);
            sb.delete(); sq.delete();
        end else begin
            e = sb.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("carry", 32'(carry), 32'(e.c));
            chk("latency", cyc, lat_exp);
            chk("sout_vld_cycles", nvld, e.nshift);
            chk("busy_cycles", nbusy, e.nshift + 1);
            chk("sout_left", sq.size(), 0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        start = 1'b1; din = v.din; amt = v.amt;
        push_exp(v.din, v.amt, v.res, v.c);
        @(posedge clk); #1;
        start = 1'b0; din = ~v.din;
        wait_done(int'(v.amt) + 1);
        @(negedge clk);
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_hold", 32'(result), 32'(v.res));
    endtask

    initial begin
        vecs[0] = '{4'b1011, 3'd1, 4'b0101, 1'b1};
        vecs[1] = '{4'b1011, 3'd3, 4'b0001, 1'b0};
        vecs[2] = '{4'b1011, 3'd0, 4'b1011, 1'b0};
        vecs[3] = '{4'b1111, 3'd7, 4'b0000, 1'b0};
        vecs[4] = '{4'b1111, 3'd4, 4'b0000, 1'b1};
        vecs[5] = '{4'b1000, 3'd4, 4'b0000, 1'b1};
        vecs[6] = '{4'b1000, 3'd5, 4'b0000, 1'b0};
        vecs[7] = '{4'b0110, 3'd2, 4'b0001, 1'b1};
        vecs[8] = '{4'b1001, 3'd1, 4'b0100, 1'b1};

        rst = 1'b1; start = 1'b0; din = '0; amt = '0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_carry", 32'(carry), 0);
        chk("rst_sout_vld", 32'(sout_vld), 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_start", 32'(busy), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // A second start during SHIFT is dropped; a start held through DONE is taken in IDLE.
        @(negedge clk);
        start = 1'b1; din = 4'b1011; amt = 3'd3;
        push_exp(4'b1011, 3'd3, 4'b0001, 1'b0);
        @(posedge clk); #1;
        din = 4'b0110; amt = 3'd2;
        wait_done(4);
        @(negedge clk);
        chk("held_idle_busy", 32'(busy), 0);
        push_exp(4'b0110, 3'd2, 4'b0001, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3);

        // Asynchronous reset mid-shift, away from any clock edge.
        @(negedge clk);
        start = 1'b1; din = 4'b1111; amt = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_done", 32'(done), 0);
        chk("async_result", 32'(result), 0);
        chk("async_carry", 32'(carry), 0);
        chk("async_sout_vld", 32'(sout_vld), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 0);

        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
